fir_out_requant: RTL and testbench
==================================

Name: fir_out_requant

Overview:
- Output-side consumer of the FIR datapath.
- Accepts full-precision accumulator results over a valid/ready stream.
- Discards the first TAPS-1 warm-up results, rounds and right-shifts by BIT_PREC, and saturates to DWIDTH signed.
- Buffers results in a small FIFO toward the downstream sink (output-wave capture / next stage).

Parameters:
- TAPS, 20: filter length; warm-up discard count is TAPS-1.
- BIT_PREC, 4: fractional bits of the coefficients; right-shift amount.
- DWIDTH, 32: signed output sample width.
- AWIDTH, 64: signed accumulator input width; must be > DWIDTH+BIT_PREC.
- DEPTH, 4: output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of FIFO, warm-up counter and sat_cnt.
- in_valid  in  1  accumulator result valid.
- in_ready  out  1  block can accept a result.
- in_data  in  AWIDTH  signed accumulator result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DWIDTH  signed requantized sample (FIFO head).
- warm_done  out  1  high once TAPS-1 results have been discarded.
- sat_cnt  out  16  count of saturated outputs; saturates at 0xFFFF.

Behaviour:
- Reset (rst=1, async): FIFO empty, out_valid=0, out_data=0, warm_done=0, warm-up counter=0, sat_cnt=0.
  - in_ready=0 while rst is high; in_ready=1 the first cycle after release.
- Input accept: in_valid & in_ready at a rising edge.
  - in_ready = (FIFO count < DEPTH) & ~flush. It is registered-count based, with no same-cycle pop passthrough.
  - When full and popping in the same cycle, in_ready stays 0 that cycle.
- Warm-up:
  - While warm_done=0, each accept increments the warm-up counter and nothing is written to the FIFO.
  - When the counter reaches TAPS-1, warm_done=1 and stays high until flush or rst.
  - The accept that makes the count TAPS-1 is itself discarded.
- Requantization is combinational on in_data, written to the FIFO on the accept edge:
  - r = (sign-extend(in_data, AWIDTH+1) + 2^(BIT_PREC-1)) >>> BIT_PREC, arithmetic shift (round half toward +inf).
  - If r > 2^(DWIDTH-1)-1, out = 0x7FF..F. If r < -2^(DWIDTH-1), out = 0x800..0. Otherwise out = r[DWIDTH-1:0].
  - Each clamped write increments sat_cnt (saturating at 0xFFFF). Discarded warm-up samples never count.
- Latency: an accepted post-warm-up result is visible at out_data with out_valid=1 on the cycle after the accept edge, if the FIFO was empty.
- Output handshake:
  - Pop on out_valid & out_ready.
  - out_data holds the head stable while out_valid=1 and out_ready=0.
  - Strict FIFO order; no drops after warm-up.
- Simultaneous push and pop: count unchanged; pointers both advance, wrapping modulo DEPTH.
- Flush:
  - Next edge empties the FIFO and sets out_valid=0, out_data=0, warm_done=0, counter=0, sat_cnt=0.
  - An in_valid present in the flush cycle is not accepted (in_ready=0).
- rst asserted mid-stream discards all buffered data immediately (async); no partial state survives.
- out_data is 0 whenever out_valid=0.

Test Plan:
- Warm-up:
  - Stimulus: after reset, stream in_data = k*16 for k=0..24, out_ready=1.
  - Required: k=0..18 discarded; warm_done rises after the 19th accept; out_data = 19,20,...,24; sat_cnt=0.
- Rounding (post warm-up):
  - Stimulus: in_data = 7, 8, 24, -24, -25.
  - Required: out_data = 0, 1, 2, -1, -2.
- Saturation:
  - Stimulus: in_data = 2^40, -2^40, 0x7FFFFFFF0, 0x7FFFFFFF8.
  - Required: out_data = 0x7FFFFFFF, 0x80000000, 0x7FFFFFFF, 0x7FFFFFFF; sat_cnt ends at 3 (the third value is not saturated).
- Backpressure (post warm-up):
  - Stimulus: out_ready=0, 6 back-to-back in_valid with values 1..6 (x16).
  - Required: 4 accepted, then in_ready=0; out_data stable at 1.
  - Release: raise out_ready for 1 cycle. Required: in_ready returns, and pops yield 1,2,3,4,5,6 in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full, out_ready=1, in_valid=1 continuous.
  - Required: in_ready=0 for exactly one cycle, then alternates per count; no loss, no duplication over 20 samples.
- Flush/reset mid-operation:
  - Stimulus: 3 entries buffered and sat_cnt=2, then pulse flush.
  - Required: next cycle out_valid=0, warm_done=0, sat_cnt=0; the next 19 inputs are discarded again.
  - Stimulus: repeat with rst asserted asynchronously between edges.
  - Required: outputs clear immediately.

Source files
------------

// File: rtl/fir_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_requant
// Purpose  : Drops FIR warm-up results, then rounds, shifts and saturates each
//            accumulator value and queues it in a small output FIFO.
// Revision : 1.0
// ============================================================================
module fir_out_requant #(
  parameter int TAPS     = 20,
  parameter int BIT_PREC = 4,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 64,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              warm_done,
  output logic [15:0]       sat_cnt
);

  localparam int                     c_pw        = $clog2(DEPTH);
  localparam int                     c_ww        = $clog2(TAPS + 1);
  localparam logic [c_pw:0]          c_depth     = (c_pw + 1)'(DEPTH);
  localparam logic [c_pw:0]          c_cnt_one   = (c_pw + 1)'(1);
  localparam logic [c_pw-1:0]        c_ptr_one   = c_pw'(1);
  localparam logic [c_ww-1:0]        c_warm_one  = c_ww'(1);
  localparam logic [c_ww-1:0]        c_warm_last = c_ww'(TAPS - 2);
  localparam logic signed [AWIDTH:0] c_half      = ((AWIDTH + 1)'(1) << BIT_PREC) >> 1;

  logic [c_pw-1:0]   r_wr_ptr;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [c_pw:0]     r_count;
  logic [c_ww-1:0]   r_warm_cnt;
  logic              r_warm_done;
  logic [15:0]       r_sat_cnt;
  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_out_valid;
  logic signed [AWIDTH:0]   w_ext;
  logic signed [AWIDTH:0]   w_sum;
  logic signed [AWIDTH:0]   w_r;
  logic [AWIDTH-DWIDTH+1:0] w_hi;
  logic                     w_pos_ovf;
  logic                     w_neg_ovf;
  logic [DWIDTH-1:0]        w_q;

  // Extra sign bit keeps the rounding add from overflowing near the input extremes.
  always_comb begin
    w_ext     = {in_data[AWIDTH-1], in_data};
    w_sum     = w_ext + c_half;
    w_r       = w_sum >>> BIT_PREC;
    w_hi      = w_r[AWIDTH:DWIDTH-1];
    w_pos_ovf = ~w_r[AWIDTH] & (|w_hi);
    w_neg_ovf = w_r[AWIDTH] & ~(&w_hi);
    w_q       = w_r[DWIDTH-1:0];
    if (w_pos_ovf) begin
      w_q = {1'b0, {(DWIDTH-1){1'b1}}};
    end else if (w_neg_ovf) begin
      w_q = {1'b1, {(DWIDTH-1){1'b0}}};
    end
  end

  // Ready depends only on the registered count; a pop in a full cycle does not free a slot early.
  assign w_in_ready  = ~rst & ~flush & (r_count < c_depth);
  assign w_accept    = in_valid & w_in_ready;
  assign w_push      = w_accept & r_warm_done;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_warm_cnt  <= '0;
      r_warm_done <= 1'b0;
      r_sat_cnt   <= '0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_warm_cnt  <= '0;
      r_warm_done <= 1'b0;
      r_sat_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (w_accept & ~r_warm_done) begin
        r_warm_cnt <= r_warm_cnt + c_warm_one;
        if (r_warm_cnt == c_warm_last) begin
          r_warm_done <= 1'b1;
        end
      end
      if (w_push & (w_pos_ovf | w_neg_ovf) & (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_q;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign warm_done = r_warm_done;
  assign sat_cnt   = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_out_requant
// Purpose  : Self-checking bench for fir_out_requant (vector table, directed
//            corner sequences and randomized traffic against a queue model).
// Revision : 1.0
// ============================================================================
module tb_fir_out_requant;
  localparam int TAPS  = 20;
  localparam int BP    = 4;
  localparam int DW    = 32;
  localparam int AW    = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          warm_done;
  logic [DW-1:0] out_data;
  logic [15:0]   sat_cnt;

  always #5 clk = ~clk;

  fir_out_requant #(.TAPS(TAPS), .BIT_PREC(BP), .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .warm_done(warm_done), .sat_cnt(sat_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_q[$];
  int            m_warm;
  bit            m_done;
  int            m_sat;
  bit            last_acc;
  int            n_push;
  int            dut_pops;

  typedef struct {
    logic [63:0] din;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Round half toward +inf = floor((x + 2^(BP-1)) / 2^BP), then clamp to DW signed.
  function automatic void ref_requant(input logic [AW-1:0] x, output logic [DW-1:0] y,
                                      output bit sat);
    logic signed [AW:0] r;
    longint lim_hi, lim_lo;
    lim_hi = (64'sd1 <<< (DW - 1)) - 1;
    lim_lo = -(64'sd1 <<< (DW - 1));
    r = $signed({x[AW-1], x});
    r = (r + (65'sd1 <<< (BP - 1))) >>> BP;
    sat = 1'b1;
    if (r > lim_hi)      y = lim_hi[DW-1:0];
    else if (r < lim_lo) y = lim_lo[DW-1:0];
    else begin
      y = r[DW-1:0];
      sat = 1'b0;
    end
  endfunction

  task automatic mreset();
    m_q.delete();
    m_warm = 0;
    m_done = 0;
    m_sat  = 0;
  endtask

  // One clock: check DUT against model at negedge, advance model, end at posedge+1.
  task automatic step();
    logic [DW-1:0] y;
    bit s, exp_rdy, exp_pop, acc;
    @(negedge clk);
    exp_rdy = (m_q.size() < DEPTH) && !flush;
    exp_pop = (m_q.size() != 0) && out_ready;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_q.size() != 0);
    chk("out_data", out_data, (m_q.size() != 0) ? m_q[0] : '0);
    chk("warm_done", warm_done, m_done);
    chk("sat_cnt", sat_cnt, m_sat);
    if (out_valid && out_ready) dut_pops++;
    acc = in_valid && exp_rdy;
    if (flush) mreset();
    else begin
      if (exp_pop) void'(m_q.pop_front());
      if (acc) begin
        if (!m_done) begin
          m_warm++;
          if (m_warm == TAPS - 1) m_done = 1;
        end else begin
          ref_requant(in_data, y, s);
          m_q.push_back(y);
          n_push++;
          if (s && m_sat < 65535) m_sat++;
        end
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] v);
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 64; i++) begin
      step();
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (m_q.size() == 0) break;
      step();
    end
    chk("drain_empty", out_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int got, p0, q0;

    tbl[0] = '{64'd7, 32'd0};
    tbl[1] = '{64'd8, 32'd1};
    tbl[2] = '{64'd24, 32'd2};
    tbl[3] = '{-64'sd24, 32'hFFFF_FFFF};
    tbl[4] = '{-64'sd25, 32'hFFFF_FFFE};
    tbl[5] = '{64'h100_0000_0000, 32'h7FFF_FFFF};
    tbl[6] = '{-64'sh100_0000_0000, 32'h8000_0000};
    tbl[7] = '{64'h7_FFFF_FFF0, 32'h7FFF_FFFF};
    tbl[8] = '{64'h7_FFFF_FFF8, 32'h7FFF_FFFF};

    mreset();
    n_push = 0;
    dut_pops = 0;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_warm_done", warm_done, 1'b0);
    chk("rst_sat_cnt", sat_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Warm-up: k*16 for k=0..24
    out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      send(64'(k * 16));
      chk("warm_flag", warm_done, k >= TAPS - 2);
      if (k >= TAPS - 1) chk("warm_out", out_data, 32'(k));
      else               chk("warm_discard", out_valid, 1'b0);
    end
    drain();
    chk("warm_sat", sat_cnt, 16'd0);

    // Rounding and saturation vectors
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].din);
      chk("vec_out", out_data, tbl[i].exp);
    end
    drain();
    chk("vec_sat", sat_cnt, 16'd3);

    // Backpressure
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) send(64'(v * 16));
    chk("bp_full_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 64'd80;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", out_data, 32'd1);
      chk("bp_no_accept", last_acc, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_ready_back", in_ready, 1'b1);
    send(64'd80);
    out_ready = 1'b1;
    send(64'd96);
    drain();

    // Full FIFO with continuous push and pop
    p0 = n_push;
    q0 = dut_pops;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(64'($urandom_range(0, 100000)));
    chk("fp_full_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    got = 0;
    in_data = 64'($urandom_range(0, 100000));
    for (int i = 0; i < 100; i++) begin
      if (got >= 20) break;
      step();
      if (last_acc) begin
        got++;
        in_data = 64'($urandom_range(0, 100000));
      end
    end
    chk("fp_accepted", got, 20);
    drain();
    chk("fp_conserve", dut_pops - q0, n_push - p0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      d = {$urandom, $urandom};
      in_data = 64'($signed(d) >>> $urandom_range(0, 40));
      step();
    end
    drain();

    // Flush mid-operation
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < TAPS - 1; k++) send(64'(k * 16));
    out_ready = 1'b0;
    send(64'h100_0000_0000);
    send(-64'sh100_0000_0000);
    send(64'd80);
    chk("fl_sat_pre", sat_cnt, 16'd2);
    chk("fl_valid_pre", out_valid, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'd77;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_out_data", out_data, 32'd0);
    chk("fl_warm_done", warm_done, 1'b0);
    chk("fl_sat_cnt", sat_cnt, 16'd0);
    out_ready = 1'b1;
    for (int k = 0; k < TAPS - 1; k++) begin
      send(64'(k * 16 + 5));
      chk("fl_rediscard", out_valid, 1'b0);
    end
    chk("fl_warm_again", warm_done, 1'b1);
    send(64'd144);
    chk("fl_first_out", out_data, 32'd9);
    drain();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send(64'h100_0000_0000);
    send(64'd32);
    send(64'd48);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_out_data", out_data, 32'd0);
    chk("ar_warm_done", warm_done, 1'b0);
    chk("ar_sat_cnt", sat_cnt, 16'd0);
    chk("ar_in_ready", in_ready, 1'b0);
    mreset();
    rst = 1'b0;
    out_ready = 1'b1;
    send(64'd16);
    chk("ar_discard", out_valid, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
